// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2s_pkg
// Brief    : Shared constants for the I2S capture path (widths, channels, FSM).
// Revision : 1.0  initial release
// ============================================================================
package i2s_pkg;

  localparam int c_DEFAULT_BITSIZE     = 16;
  localparam int c_DEFAULT_SYNC_STAGES = 2;

  localparam logic c_LEFT  = 1'b0;
  localparam logic c_RIGHT = 1'b1;

  localparam logic [0:0] c_ST_SYNC = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

  typedef enum logic [0:0] {
    ST_SYNC = c_ST_SYNC,
    ST_RUN  = c_ST_RUN
  } state_t;

endpackage
`default_nettype wire

// File: rtl/i2s_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_capture_if
// Brief    : I2S serial inputs plus stereo-pair valid/ready output bundle.
// Revision : 1.0  initial release
// ============================================================================
interface i2s_capture_if
  import i2s_pkg::*;
#(
  parameter int BITSIZE = c_DEFAULT_BITSIZE
) ();

  logic               bclk;
  logic               lrclk;
  logic               sdata;
  logic [BITSIZE-1:0] left_chan;
  logic [BITSIZE-1:0] right_chan;
  logic               out_valid;
  logic               out_ready;
  logic               overrun;
  logic               short_word;
  logic               synced;

  modport slave (
    input  bclk, lrclk, sdata, out_ready,
    output left_chan, right_chan, out_valid, overrun, short_word, synced
  );

  modport master (
    output bclk, lrclk, sdata, out_ready,
    input  left_chan, right_chan, out_valid, overrun, short_word, synced
  );

endinterface
`default_nettype wire

// File: rtl/i2s_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : i2s_sync_edge
// Brief    : Equal-depth synchroniser for an edge input and data bits, with
//            a one-clk rising-edge strobe on the edge input.
// Revision : 1.0  initial release
// ============================================================================
module i2s_sync_edge
  import i2s_pkg::*;
#(
  parameter int DATA_W = 2,
  parameter int STAGES = c_DEFAULT_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_edge,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_rise,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W:0] r_chain [STAGES];
  logic [DATA_W:0] w_last;
  logic            r_prev;

  // Edge and data share one chain so the data seen at a strobe is aligned.
  always_ff @(posedge clk) begin
    r_chain[0] <= {i_data, i_edge};
    for (int i = 1; i < STAGES; i++) begin
      r_chain[i] <= r_chain[i-1];
    end
  end

  assign w_last = r_chain[STAGES-1];

  // Reset to 1 so a high bclk at reset release is not taken as a rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= w_last[0];
    end
  end

  assign o_rise = w_last[0] & ~r_prev;
  assign o_data = w_last[DATA_W:1];

endmodule
`default_nettype wire

// File: rtl/i2s_capture.sv
`default_nettype none
// ============================================================================
// Module   : i2s_capture
// Brief    : I2S receiver: bit deserialiser, frame alignment and stereo-pair
//            valid/ready holding register with overrun/short-word status.
// Revision : 1.0  initial release
// ============================================================================
module i2s_capture
  import i2s_pkg::*;
#(
  parameter int BITSIZE     = c_DEFAULT_BITSIZE,
  parameter int SYNC_STAGES = c_DEFAULT_SYNC_STAGES
) (
  input  logic          clk,
  input  logic          rst,
  i2s_capture_if.slave  bus
);

  localparam int c_CW = $clog2(BITSIZE + 1);
  localparam int c_IW = (BITSIZE > 1) ? $clog2(BITSIZE) : 1;
  localparam logic [c_CW-1:0]    c_FULL = c_CW'(BITSIZE);
  localparam logic [BITSIZE-1:0] c_MSB  = BITSIZE'(1) << (BITSIZE - 1);

  logic               w_rise;
  logic [1:0]         w_data;
  logic               w_lr;
  logic               w_bit;
  logic               r_lr_d;
  logic               r_ch_prev;
  logic [BITSIZE-1:0] r_shift;
  logic [c_CW-1:0]    r_count;
  logic [c_IW-1:0]    w_idx;
  logic               w_full;
  logic               w_boundary;
  logic               w_commit;
  logic               w_pair;
  logic [BITSIZE-1:0] r_stage;
  logic               r_stage_ok;
  logic [BITSIZE-1:0] r_left_out;
  logic [BITSIZE-1:0] r_right_out;
  logic               r_valid;
  logic               r_overrun;
  logic               r_short;
  state_t             r_state;
  state_t             w_next;

  i2s_sync_edge #(
    .DATA_W (2),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_edge (bus.bclk),
    .i_data ({bus.sdata, bus.lrclk}),
    .o_rise (w_rise),
    .o_data (w_data)
  );

  assign w_lr  = w_data[0];
  assign w_bit = w_data[1];

  // I2S one-bit delay: a bit belongs to the channel selected one bclk earlier.
  assign w_boundary = w_rise && (r_lr_d != r_ch_prev);
  assign w_commit   = w_boundary && (r_state == ST_RUN);
  assign w_pair     = w_commit && (r_ch_prev == c_RIGHT) && r_stage_ok;
  assign w_full     = (r_count == c_FULL);
  assign w_idx      = c_IW'(BITSIZE - 1 - int'(r_count));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_SYNC;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if ((r_state == ST_SYNC) && w_boundary && (r_lr_d == c_LEFT)) begin
      w_next = ST_RUN;
    end
  end

  // Words are built left-justified, so short words need no realignment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lr_d     <= c_LEFT;
      r_ch_prev  <= c_LEFT;
      r_shift    <= '0;
      r_count    <= '0;
      r_stage    <= '0;
      r_stage_ok <= 1'b0;
    end else if (w_rise) begin
      r_lr_d    <= w_lr;
      r_ch_prev <= r_lr_d;
      if (w_boundary) begin
        r_shift <= w_bit ? c_MSB : '0;
        r_count <= c_CW'(1);
      end else if (!w_full) begin
        r_shift[w_idx] <= w_bit;
        r_count        <= r_count + c_CW'(1);
      end
      if (w_commit) begin
        if (r_ch_prev == c_LEFT) begin
          r_stage    <= r_shift;
          r_stage_ok <= 1'b1;
        end else begin
          r_stage_ok <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_left_out  <= '0;
      r_right_out <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_short     <= 1'b0;
    end else begin
      r_short <= w_commit && !w_full;
      if (w_pair && (!r_valid || bus.out_ready)) begin
        r_left_out  <= r_stage;
        r_right_out <= r_shift;
        r_valid     <= 1'b1;
      end else if (w_pair) begin
        r_overrun <= 1'b1;
      end else if (r_valid && bus.out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.left_chan  = r_left_out;
  assign bus.right_chan = r_right_out;
  assign bus.out_valid  = r_valid;
  assign bus.overrun    = r_overrun;
  assign bus.short_word = r_short;
  assign bus.synced     = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_i2s_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_capture
// Brief    : Scoreboard bench: slot-level I2S codec model drives the DUT and
//            predicts stereo pairs, overrun and short-word counts.
// Revision : 1.0  initial release
// ============================================================================
module tb_i2s_capture;
  import i2s_pkg::*;

  localparam int c_B = 16;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2s_capture_if #(.BITSIZE(c_B)) bus ();

  i2s_capture #(
    .BITSIZE     (c_B),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pair_t       exp_q[$];
  pair_t       mon_got;
  pair_t       mon_exp;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_short_dut = 0;

  bit          m_synced;
  bit          m_have_prev;
  bit          m_prev_ch;
  bit          m_left_ok;
  bit          m_held;
  bit          m_overrun;
  logic [15:0] m_prev_word;
  logic [15:0] m_left;
  int          m_prev_len;
  int          m_short_exp = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pair is popped against the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      mon_got = {bus.left_chan, bus.right_chan};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL pair_unexpected: got %h expected none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pair", mon_got, mon_exp);
      end
    end
    if (!rst && bus.short_word) n_short_dut++;
  end

  // ---------------- reference model (slot level) ----------------
  function automatic logic [15:0] justify(logic [15:0] w, int len);
    if (len >= c_B) return w;
    return w & ~(16'hFFFF >> len);
  endfunction

  task automatic m_reset();
    m_synced = 0; m_have_prev = 0; m_prev_ch = 0; m_left_ok = 0;
    m_held = 0; m_overrun = 0; m_prev_word = '0; m_left = '0; m_prev_len = 0;
    exp_q.delete();
  endtask

  task automatic m_commit(bit ch, logic [15:0] w, bit short_w);
    if (short_w) m_short_exp++;
    if (ch == c_LEFT) begin
      m_left    = w;
      m_left_ok = 1;
    end else if (m_left_ok) begin
      m_left_ok = 0;
      if (!m_held || bus.out_ready) begin
        exp_q.push_back({m_left, w});
        m_held = !bus.out_ready;
      end else begin
        m_overrun = 1;
      end
    end
  endtask

  // Called as a slot's MSB goes out: the previous slot's word ends here.
  task automatic m_slot_start(bit ch, logic [15:0] w, int len);
    if (m_have_prev && ch != m_prev_ch) begin
      if (m_synced) m_commit(m_prev_ch, justify(m_prev_word, m_prev_len), m_prev_len < c_B);
      else if (ch == c_LEFT) m_synced = 1;
    end
    m_have_prev = 1; m_prev_ch = ch; m_prev_word = w; m_prev_len = len;
  endtask

  // ---------------- codec driver ----------------
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive_bit(bit lr, bit d);
    bus.bclk = 1'b0; bus.lrclk = lr; bus.sdata = d;
    tick(2);
    bus.bclk = 1'b1;
    tick(2);
  endtask

  // Word select flips one bclk ahead of the next slot's MSB.
  task automatic send_bits(bit ch, logic [15:0] w, int from, int len);
    for (int i = from; i < len; i++) begin
      drive_bit((i == len - 1) ? ~ch : ch, (i < c_B) ? w[c_B-1-i] : 1'b0);
    end
  endtask

  task automatic send_slot(bit ch, logic [15:0] w, int len);
    m_slot_start(ch, w, len);
    send_bits(ch, w, 0, len);
  endtask

  task automatic send_frame(logic [15:0] l, logic [15:0] r, int len = 32);
    send_slot(c_LEFT, l, len);
    send_slot(c_RIGHT, r, len);
  endtask

  task automatic idle(int n);
    bus.bclk = 1'b0;
    tick(n);
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_left"},     32'(bus.left_chan),  32'h0);
    check({tag, "_right"},    32'(bus.right_chan), 32'h0);
    check({tag, "_valid"},    32'(bus.out_valid),  32'h0);
    check({tag, "_overrun"},  32'(bus.overrun),    32'h0);
    check({tag, "_short"},    32'(bus.short_word), 32'h0);
    check({tag, "_synced"},   32'(bus.synced),     32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.bclk = 1'b0; bus.lrclk = 1'b0; bus.sdata = 1'b0; bus.out_ready = 1'b1;
    m_reset();
    tick(4);
    rst = 1'b0;
    check_zero_outputs("reset");

    // Acquisition: start partway through a right slot.
    send_bits(c_RIGHT, 16'hFFFF, 8, 32);
    m_have_prev = 1; m_prev_ch = c_RIGHT;
    idle(8);
    check("acq_synced_pre", 32'(bus.synced), 32'(m_synced));
    check("acq_valid_pre", 32'(bus.out_valid), 32'h0);
    send_slot(c_LEFT, 16'hC3C3, 32);
    idle(8);
    check("acq_synced_post", 32'(bus.synced), 32'(m_synced));
    check("acq_valid_post", 32'(bus.out_valid), 32'h0);
    send_slot(c_RIGHT, 16'h3C3C, 32);

    // Basic pair.
    send_frame(16'hA5A5, 16'h1234);
    send_frame(16'h0F0F, 16'hF0F0);
    idle(8);
    check("basic_overrun", 32'(bus.overrun), 32'(m_overrun));
    check("basic_short_cnt", 32'(n_short_dut), 32'(m_short_exp));
    check("basic_drained", 32'(exp_q.size()), 32'h0);

    // Back-to-back acceptance.
    for (int k = 1; k <= 8; k++) send_frame(16'(k), 16'(k));
    send_frame(16'h7777, 16'h8888);
    idle(8);
    check("b2b_drained", 32'(exp_q.size()), 32'h0);
    check("b2b_overrun", 32'(bus.overrun), 32'(m_overrun));

    // Random words and slot lengths.
    for (int k = 0; k < 10; k++) begin
      send_frame(16'($urandom), 16'($urandom), int'($urandom_range(2, 32)));
    end
    send_frame(16'($urandom), 16'($urandom));
    idle(8);
    check("rand_drained", 32'(exp_q.size()), 32'h0);
    check("rand_short_cnt", 32'(n_short_dut), 32'(m_short_exp));

    // Backpressure across two frames.
    rst = 1'b1; m_reset(); tick(2); rst = 1'b0;
    send_bits(c_RIGHT, 16'h0000, 20, 32);
    m_have_prev = 1; m_prev_ch = c_RIGHT;
    bus.out_ready = 1'b0;
    send_frame(16'h1111, 16'h2222);
    send_frame(16'h3333, 16'h4444);
    send_frame(16'h5555, 16'h6666);
    idle(8);
    check("bp_valid_held", 32'(bus.out_valid), 32'h1);
    check("bp_left_held", 32'(bus.left_chan), 32'h1111);
    check("bp_right_held", 32'(bus.right_chan), 32'h2222);
    check("bp_overrun", 32'(bus.overrun), 32'(m_overrun));
    bus.out_ready = 1'b1;
    m_held = 0;
    tick(1);
    check("bp_valid_clear", 32'(bus.out_valid), 32'h0);
    check("bp_overrun_sticky", 32'(bus.overrun), 32'h1);

    // Short slots: 8 bclk per slot.
    for (int k = 0; k < 3; k++) send_frame(16'hAB00, 16'hCD00, 8);
    send_frame(16'h1357, 16'h2468);
    idle(8);
    check("short_cnt", 32'(n_short_dut), 32'(m_short_exp));
    check("short_drained", 32'(exp_q.size()), 32'h0);

    // Reset during a left slot.
    m_slot_start(c_LEFT, 16'h5555, 32);
    send_bits(c_LEFT, 16'h5555, 0, 10);
    check("pre_rst_drained", 32'(exp_q.size()), 32'h0);
    rst = 1'b1; m_reset(); tick(1); rst = 1'b0;
    check_zero_outputs("midrst");
    send_bits(c_LEFT, 16'h5555, 10, 32);
    m_have_prev = 1; m_prev_ch = c_LEFT;
    send_slot(c_RIGHT, 16'hAAAA, 32);
    send_frame(16'h6666, 16'h9999);
    send_frame(16'h1357, 16'h2468);
    idle(8);
    check("midrst_drained", 32'(exp_q.size()), 32'h0);
    check("midrst_overrun", 32'(bus.overrun), 32'(m_overrun));
    check("final_short_cnt", 32'(n_short_dut), 32'(m_short_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
